// File: rtl/gpr_sb.sv
// Parametrised GPR file with write-to-read bypass, busy scoreboard and a valid/ready dump engine.
// Optional: define GPR_R0_ZERO_EN to hardwire r0 to zero.
module gpr_sb #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_dest,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic                  busy_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  busy_2,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_dest,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

`ifdef GPR_R0_ZERO_EN
    localparam bit R0Zero = 1'b1;
`else
    localparam bit R0Zero = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StSend} dump_state_e;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;

    logic wr_ok;
    logic rsv_ok;
    logic hit_1;
    logic hit_2;

    assign wr_ok  = write_en && !(R0Zero && (write_dest == '0));
    assign rsv_ok = reserve_en && !(R0Zero && (reserve_dest == '0));
    assign hit_1  = write_en && (write_dest == read_addr_1);
    assign hit_2  = write_en && (write_dest == read_addr_2);

    // Register array and scoreboard next state; reserve is applied last so it wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[write_dest] = write_data;
        end
        if (write_en) begin
            busy_d[write_dest] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[reserve_dest] = 1'b1;
        end
    end

    always_comb begin
        read_data_1 = regs_q[read_addr_1];
        if (hit_1) begin
            read_data_1 = write_data;
        end
        if (R0Zero && (read_addr_1 == '0)) begin
            read_data_1 = '0;
        end
        busy_1 = busy_q[read_addr_1] && !hit_1;
    end

    always_comb begin
        read_data_2 = regs_q[read_addr_2];
        if (hit_2) begin
            read_data_2 = write_data;
        end
        if (R0Zero && (read_addr_2 == '0)) begin
            read_data_2 = '0;
        end
        busy_2 = busy_q[read_addr_2] && !hit_2;
    end

    // Dump engine: one beat per register, addresses 0..NUM_REGS-1.
    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        dump_valid  = 1'b0;
        dump_busy   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dump_start) begin
                    state_d     = StSend;
                    dump_addr_d = '0;
                end
            end
            StSend: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (dump_addr_q == ADDR_WIDTH'(NUM_REGS - 1)) begin
                        state_d     = StIdle;
                        dump_addr_d = '0;
                    end else begin
                        dump_addr_d = dump_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dump_addr = dump_addr_q;
    // Live register contents, deliberately without bypass.
    assign dump_data = regs_q[dump_addr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q      <= '0;
            state_q     <= StIdle;
            dump_addr_q <= '0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            state_q     <= state_d;
            dump_addr_q <= dump_addr_d;
        end
    end

endmodule

// File: tb/tb_gpr_sb.sv
// Self-checking bench for gpr_sb: directed hazard/dump scenarios then randomized traffic
// against a behavioural model. Honours GPR_R0_ZERO_EN when defined.
module tb_gpr_sb;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 8;

`ifdef GPR_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en;
    logic [AW-1:0] write_dest;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_addr_1;
    logic [DW-1:0] read_data_1;
    logic          busy_1;
    logic [AW-1:0] read_addr_2;
    logic [DW-1:0] read_data_2;
    logic          busy_2;
    logic          reserve_en;
    logic [AW-1:0] reserve_dest;
    logic          dump_start;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          dump_busy;

    always #5 clk = ~clk;

    gpr_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .write_en(write_en), .write_dest(write_dest), .write_data(write_data),
        .read_addr_1(read_addr_1), .read_data_1(read_data_1), .busy_1(busy_1),
        .read_addr_2(read_addr_2), .read_data_2(read_data_2), .busy_2(busy_2),
        .reserve_en(reserve_en), .reserve_dest(reserve_dest),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [DW-1:0] m_reg [NR];
    bit            m_busy [NR];
    bit            m_dact;
    int            m_didx;

    int            beat_addr [$];
    logic [DW-1:0] beat_data [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (R0Z && a == 0) return '0;
        if (write_en && int'(write_dest) == a) return write_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input int a);
        return m_busy[a] && !(write_en && int'(write_dest) == a);
    endfunction

    // Negedge half: compare every output to the model, record transferred beats.
    task automatic half_a();
        @(negedge clk);
        check("rd1", read_data_1, exp_rd(int'(read_addr_1)));
        check("rd2", read_data_2, exp_rd(int'(read_addr_2)));
        check("busy1", busy_1, exp_busy(int'(read_addr_1)));
        check("busy2", busy_2, exp_busy(int'(read_addr_2)));
        check("dvalid", dump_valid, m_dact);
        check("dbusy", dump_busy, m_dact);
        check("daddr", dump_addr, m_dact ? m_didx : 0);
        check("ddata", dump_data, m_reg[m_dact ? m_didx : 0]);
        if (dump_valid && dump_ready && !rst) begin
            beat_addr.push_back(int'(dump_addr));
            beat_data.push_back(dump_data);
        end
    endtask

    // Posedge half: advance the model with the same inputs the DUT sees.
    task automatic half_b();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_dact = 1'b0;
            m_didx = 0;
        end else begin
            if (m_dact && dump_ready) begin
                if (m_didx == NR - 1) begin
                    m_dact = 1'b0;
                    m_didx = 0;
                end else begin
                    m_didx++;
                end
            end else if (!m_dact && dump_start) begin
                m_dact = 1'b1;
                m_didx = 0;
            end
            if (write_en) begin
                if (!(R0Z && write_dest == 0)) m_reg[write_dest] = write_data;
                m_busy[write_dest] = 1'b0;
            end
            if (reserve_en && !(R0Z && reserve_dest == 0)) m_busy[reserve_dest] = 1'b1;
        end
        #1;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; write_en = 1'b0; write_dest = '0; write_data = '0;
        reserve_en = 1'b0; reserve_dest = '0; dump_start = 1'b0; dump_ready = 1'b0;
        read_addr_1 = '0; read_addr_2 = '0;
    endtask

    task automatic run_dump(input bit toggle, input string tag);
        int n;
        beat_addr.delete();
        beat_data.delete();
        dump_start = 1'b1;
        dump_ready = 1'b1;
        cycle();
        dump_start = 1'b0;
        n = 0;
        while ((m_dact || dump_busy) && n < 40) begin
            dump_ready = toggle ? n[0] : 1'b1;
            cycle();
            n++;
        end
        check({tag, "_done"}, dump_busy, 1'b0);
        check({tag, "_beats"}, beat_addr.size(), NR);
        for (int i = 0; i < beat_addr.size() && i < NR; i++) begin
            check({tag, "_addr"}, beat_addr[i], i);
            check({tag, "_data"}, beat_data[i], (R0Z && i == 0) ? 16'h0 : 16'h10 + 16'(i));
        end
    endtask

    initial begin
        idle_inputs();
        m_dact = 1'b0;
        m_didx = 0;
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end

        // Reset and sweep all indices on both ports
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        for (int a = 0; a < NR; a++) begin
            read_addr_1 = AW'(a);
            read_addr_2 = AW'(NR - 1 - a);
            half_a();
            check("rst_rd1", read_data_1, 16'h0);
            check("rst_busy2", busy_2, 1'b0);
            half_b();
        end

        // Write with same-cycle bypass, then registered read
        write_en = 1'b1; write_dest = 3'd3; write_data = 16'hBEEF; read_addr_1 = 3'd3;
        half_a();
        check("bypass", read_data_1, 16'hBEEF);
        half_b();
        write_en = 1'b0;
        half_a();
        check("wr_read", read_data_1, 16'hBEEF);
        half_b();

        // Scoreboard: reserve, writeback release, simultaneous reserve+write
        read_addr_2 = 3'd5; reserve_en = 1'b1; reserve_dest = 3'd5;
        cycle();
        reserve_en = 1'b0;
        half_a();
        check("rsv_busy", busy_2, 1'b1);
        half_b();
        write_en = 1'b1; write_dest = 3'd5; write_data = 16'h1234;
        half_a();
        check("wb_busy_same", busy_2, 1'b0);
        half_b();
        write_en = 1'b0;
        half_a();
        check("wb_busy_next", busy_2, 1'b0);
        half_b();
        write_en = 1'b1; write_data = 16'h5678; reserve_en = 1'b1; reserve_dest = 3'd5;
        cycle();
        write_en = 1'b0; reserve_en = 1'b0;
        half_a();
        check("rsvwr_busy", busy_2, 1'b1);
        check("rsvwr_data", read_data_2, 16'h5678);
        half_b();
        write_en = 1'b1; write_data = 16'h0; // release r5
        cycle();
        write_en = 1'b0;

        // Load r0..r7 and dump, first with ready held then with ready toggling
        for (int i = 0; i < NR; i++) begin
            write_en = 1'b1; write_dest = AW'(i); write_data = 16'h10 + 16'(i);
            cycle();
        end
        write_en = 1'b0;
        run_dump(1'b0, "dump");
        run_dump(1'b1, "dumptog");

        // Reset during the dump once beat 3 is presented
        beat_addr.delete();
        beat_data.delete();
        dump_start = 1'b1; dump_ready = 1'b1;
        cycle();
        dump_start = 1'b0;
        for (int n = 0; n < 20 && !(dump_valid && dump_addr == 3'd3); n++) cycle();
        check("rstdump_at3", dump_addr, 3'd3);
        rst = 1'b1;
        cycle();
        rst = 1'b0; dump_ready = 1'b1;
        half_a();
        check("rstdump_valid", dump_valid, 1'b0);
        check("rstdump_busy", dump_busy, 1'b0);
        check("rstdump_beats", beat_addr.size(), 3);
        half_b();
        for (int a = 0; a < NR; a++) begin
            read_addr_1 = AW'(a); read_addr_2 = AW'(a);
            half_a();
            check("rstdump_reg", read_data_1, 16'h0);
            check("rstdump_sb", busy_2, 1'b0);
            half_b();
        end

        // r0 write and reserve
        read_addr_1 = 3'd0;
        write_en = 1'b1; write_dest = 3'd0; write_data = 16'hFFFF;
        reserve_en = 1'b1; reserve_dest = 3'd0;
        half_a();
        check("r0_bypass", read_data_1, R0Z ? 16'h0 : 16'hFFFF);
        half_b();
        write_en = 1'b0; reserve_en = 1'b0;
        half_a();
        check("r0_read", read_data_1, R0Z ? 16'h0 : 16'hFFFF);
        check("r0_busy", busy_1, R0Z ? 1'b0 : 1'b1);
        half_b();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            write_en     = $urandom_range(0, 1) == 1;
            write_dest   = AW'($urandom_range(0, NR - 1));
            write_data   = DW'($urandom);
            reserve_en   = $urandom_range(0, 2) == 0;
            reserve_dest = AW'($urandom_range(0, NR - 1));
            read_addr_1  = AW'($urandom_range(0, NR - 1));
            read_addr_2  = AW'($urandom_range(0, NR - 1));
            dump_start   = $urandom_range(0, 7) == 0;
            dump_ready   = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
